// File: rtl/vga_sync_gen.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : vga_sync_gen                                                   |
// | Purpose  : VGA sync/blank generation and framebuffer fetch, with a delay  |
// |            line matching sync timing to framebuffer read latency.         |
// | Option   : VGA_TEST_PATTERN_EN adds pattern_sel (colour-bar generator).   |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module vga_sync_gen #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SCALE    = 2,
  parameter int FB_W     = 160,
  parameter int ADDR_W   = 15,
  parameter int COLOR_W  = 8,
  parameter int RD_LAT   = 1,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk_25MHz,
  input  logic               reset,
  input  logic [15:0]        horiz_count,
  input  logic [15:0]        vert_count,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               pattern_sel,
`endif
  output logic [ADDR_W-1:0]  fb_addr,
  output logic               fb_rd_en,
  input  logic [COLOR_W-1:0] fb_data,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COLOR_W-1:0] rgb,
  output logic               frame_start,
  output logic [15:0]        frame_count
);

  localparam int          c_ARITH_W = ADDR_W + 1;
  localparam int          c_LAST    = RD_LAT - 1;
  localparam logic [15:0] c_h_vis   = 16'(H_VIS);
  localparam logic [15:0] c_v_vis   = 16'(V_VIS);
  localparam logic [15:0] c_h_total = 16'(H_VIS + H_FP + H_SYNC + H_BP);
  localparam logic [15:0] c_v_total = 16'(V_VIS + V_FP + V_SYNC + V_BP);
  localparam logic [15:0] c_hs_beg  = 16'(H_VIS + H_FP);
  localparam logic [15:0] c_hs_end  = 16'(H_VIS + H_FP + H_SYNC);
  localparam logic [15:0] c_vs_beg  = 16'(V_VIS + V_FP);
  localparam logic [15:0] c_vs_end  = 16'(V_VIS + V_FP + V_SYNC);
  localparam logic [c_ARITH_W-1:0] c_fb_w = c_ARITH_W'(FB_W);

  logic                 w_vis, w_in_range, w_hs, w_vs, w_first, w_pat;
  logic [15:0]          w_fb_x, w_fb_y;
  logic [c_ARITH_W-1:0] w_addr_full;
  logic [COLOR_W-1:0]   w_src;

  logic                 r_vis1, r_hs1, r_vs1, r_first1;
  logic [ADDR_W-1:0]    r_fb_addr;
  logic                 r_fb_rd_en;
  logic [RD_LAT-1:0]    r_vis_d, r_hs_d, r_vs_d, r_first_d;
  logic                 r_hsync, r_vsync, r_video_on, r_frame_start;
  logic [COLOR_W-1:0]   r_rgb;
  logic [15:0]          r_frame_count;

  // Out-of-range counts must never produce sync, so sync decode is gated by the frame bounds.
  assign w_in_range  = (horiz_count < c_h_total) && (vert_count < c_v_total);
  assign w_vis       = (horiz_count < c_h_vis) && (vert_count < c_v_vis);
  assign w_hs        = w_in_range && (horiz_count >= c_hs_beg) && (horiz_count < c_hs_end);
  assign w_vs        = w_in_range && (vert_count >= c_vs_beg) && (vert_count < c_vs_end);
  assign w_first     = (horiz_count == 16'd0) && (vert_count == 16'd0);
  assign w_fb_x      = horiz_count >> SCALE;
  assign w_fb_y      = vert_count >> SCALE;
  assign w_addr_full = c_ARITH_W'(w_fb_y) * c_fb_w + c_ARITH_W'(w_fb_x);

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]         w_bar;
  logic [COLOR_W-1:0] w_pat_rgb;
  logic               r_pat1;
  logic [COLOR_W-1:0] r_pat_rgb1;
  logic [RD_LAT-1:0]  r_pat_d;
  logic [COLOR_W-1:0] r_pat_rgb_d [RD_LAT];

  assign w_bar     = horiz_count[9:7];
  assign w_pat_rgb = COLOR_W'({{3{w_bar[2]}}, {3{w_bar[1]}}, {2{w_bar[0]}}});
  assign w_pat     = pattern_sel;
  assign w_src     = r_pat_d[c_LAST] ? r_pat_rgb_d[c_LAST] : fb_data;

  // The bar colour rides the same delay line so pattern timing equals framebuffer timing.
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_pat1     <= 1'b0;
      r_pat_rgb1 <= '0;
      r_pat_d    <= '0;
      for (int i = 0; i < RD_LAT; i++) r_pat_rgb_d[i] <= '0;
    end else begin
      r_pat1         <= pattern_sel;
      r_pat_rgb1     <= w_pat_rgb;
      r_pat_d[0]     <= r_pat1;
      r_pat_rgb_d[0] <= r_pat_rgb1;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pat_d[i]     <= r_pat_d[i-1];
        r_pat_rgb_d[i] <= r_pat_rgb_d[i-1];
      end
    end
  end
`else
  assign w_pat = 1'b0;
  assign w_src = fb_data;
`endif

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_vis1     <= 1'b0;
      r_hs1      <= 1'b0;
      r_vs1      <= 1'b0;
      r_first1   <= 1'b0;
      r_fb_addr  <= '0;
      r_fb_rd_en <= 1'b0;
    end else begin
      r_vis1     <= w_vis;
      r_hs1      <= w_hs;
      r_vs1      <= w_vs;
      r_first1   <= w_first;
      r_fb_rd_en <= w_vis && !w_pat;
      if (w_vis) r_fb_addr <= w_addr_full[ADDR_W-1:0];
    end
  end

  // RD_LAT stages so the flags line up with fb_data arriving from the memory.
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_vis_d   <= '0;
      r_hs_d    <= '0;
      r_vs_d    <= '0;
      r_first_d <= '0;
    end else begin
      r_vis_d[0]   <= r_vis1;
      r_hs_d[0]    <= r_hs1;
      r_vs_d[0]    <= r_vs1;
      r_first_d[0] <= r_first1;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vis_d[i]   <= r_vis_d[i-1];
        r_hs_d[i]    <= r_hs_d[i-1];
        r_vs_d[i]    <= r_vs_d[i-1];
        r_first_d[i] <= r_first_d[i-1];
      end
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_hsync       <= r_hs_d[c_LAST] ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= r_vs_d[c_LAST] ? SYNC_POL : ~SYNC_POL;
      r_video_on    <= r_vis_d[c_LAST];
      r_rgb         <= r_vis_d[c_LAST] ? w_src : '0;
      r_frame_start <= r_first_d[c_LAST];
      if (r_first_d[c_LAST]) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign fb_addr     = r_fb_addr;
  assign fb_rd_en    = r_fb_rd_en;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign rgb         = r_rgb;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_vga_sync_gen                                                |
// | Purpose  : Scoreboard bench for vga_sync_gen with a latency-RD_LAT memory. |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module tb_vga_sync_gen;
  localparam int LAT = 1;
  localparam int AW  = 15;
  localparam int CW  = 8;

  logic          clk_25MHz = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   horiz_count = 16'd799;
  logic [15:0]   vert_count = 16'd524;
  logic [AW-1:0] fb_addr;
  logic          fb_rd_en;
  logic [CW-1:0] fb_data;
  logic          hsync, vsync, video_on, frame_start;
  logic [CW-1:0] rgb;
  logic [15:0]   frame_count;
`ifdef VGA_TEST_PATTERN_EN
  logic          pattern_sel = 1'b0;
`endif

  vga_sync_gen #(.RD_LAT(LAT)) dut (
    .clk_25MHz  (clk_25MHz),
    .reset      (reset),
    .horiz_count(horiz_count),
    .vert_count (vert_count),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .fb_addr    (fb_addr),
    .fb_rd_en   (fb_rd_en),
    .fb_data    (fb_data),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .rgb        (rgb),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  function automatic logic [7:0] mem(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hE4;
  endfunction

  logic [CW-1:0] rd_pipe [LAT];
  initial for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
  always @(posedge clk_25MHz) begin
    if (fb_rd_en) rd_pipe[0] <= mem(fb_addr);
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign fb_data = rd_pipe[LAT-1];

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic          rd;
  } addr_exp_t;

  typedef struct {
    int            due;
    logic          hs, vs, von, fs;
    logic [CW-1:0] rgb;
    logic [15:0]   fc;
  } out_exp_t;

  addr_exp_t qa[$];
  out_exp_t  qo[$];
  string     qo_tag[$];

  int            cyc = 0, total = 0, bad = 0, hs_low = 0;
  logic [AW-1:0] m_addr = '0;
  logic [15:0]   m_fc = 16'd0;

  // Monitor: pops every expectation whose due cycle has arrived.
  initial begin
    forever begin
      @(posedge clk_25MHz);
      cyc++;
      #1;
      if (hsync == 1'b0) hs_low++;
      while (qa.size() != 0 && qa[0].due <= cyc) begin
        addr_exp_t a;
        a = qa.pop_front();
        total++;
        if (a.due != cyc || fb_rd_en !== a.rd || (a.rd && fb_addr !== a.addr)) begin
          bad++;
          $display("FAIL fb_addr cyc=%0d got addr=%0d rd=%b expected addr=%0d rd=%b",
                   cyc, fb_addr, fb_rd_en, a.addr, a.rd);
        end
      end
      while (qo.size() != 0 && qo[0].due <= cyc) begin
        out_exp_t o;
        string    t;
        o = qo.pop_front();
        t = qo_tag.pop_front();
        total++;
        if (o.due != cyc || {hsync, vsync, video_on, frame_start, rgb, frame_count}
                            !== {o.hs, o.vs, o.von, o.fs, o.rgb, o.fc}) begin
          bad++;
          $display("FAIL %s cyc=%0d got hs=%b vs=%b von=%b fs=%b rgb=%h fc=%h expected hs=%b vs=%b von=%b fs=%b rgb=%h fc=%h",
                   t, cyc, hsync, vsync, video_on, frame_start, rgb, frame_count,
                   o.hs, o.vs, o.von, o.fs, o.rgb, o.fc);
        end
      end
    end
  end

  task automatic drive(input int x, input int y, input bit chk, input bit pat, input string tag);
    bit            vis, inr, hs, vs, first;
    logic [9:0]    xv;
    logic [2:0]    b;
    logic [CW-1:0] exp_rgb;
    @(negedge clk_25MHz);
    reset       = 1'b0;
    horiz_count = 16'(x);
    vert_count  = 16'(y);
`ifdef VGA_TEST_PATTERN_EN
    pattern_sel = pat;
`endif
    vis   = (x < 640) && (y < 480);
    inr   = (x < 800) && (y < 525);
    hs    = inr && (x >= 656) && (x < 752);
    vs    = inr && (y >= 490) && (y < 492);
    first = (x == 0) && (y == 0);
    if (vis) m_addr = AW'((y / 4) * 160 + (x / 4));
    if (first) m_fc = m_fc + 16'd1;
    xv = 10'(x);
    b  = xv[9:7];
    if (!vis)     exp_rgb = '0;
    else if (pat) exp_rgb = {{3{b[2]}}, {3{b[1]}}, {2{b[0]}}};
    else          exp_rgb = mem(m_addr);
    if (chk) begin
      qa.push_back('{due: cyc + 1, addr: m_addr, rd: vis && !pat});
      qo.push_back('{due: cyc + LAT + 2, hs: !hs, vs: !vs, von: vis, fs: first,
                     rgb: exp_rgb, fc: m_fc});
      qo_tag.push_back(tag);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_25MHz);
      reset  = 1'b1;
      m_addr = '0;
      m_fc   = 16'd0;
      qa.push_back('{due: cyc + 1, addr: '0, rd: 1'b0});
      qo.push_back('{due: cyc + 1, hs: 1'b1, vs: 1'b1, von: 1'b0, fs: 1'b0,
                     rgb: '0, fc: 16'd0});
      qo_tag.push_back("reset_state");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qo.size() != 0) && n < 20) begin
      drive(799, 524, 1'b0, 1'b0, "idle");
      n++;
    end
    total++;
    if (qa.size() != 0 || qo.size() != 0) begin
      bad++;
      $display("FAIL drain pending addr=%0d out=%0d expected 0", qa.size(), qo.size());
    end
  endtask

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset(5);
    drain();

    // One full line: hsync low exactly 656..751.
    hs_low = 0;
    for (int x = 0; x < 800; x++) drive(x, 1, 1'b1, 1'b0, "line_y1");
    drain();
    total++;
    if (hs_low != 96) begin
      bad++;
      $display("FAIL hsync_width got=%0d expected=96", hs_low);
    end

    for (int y = 488; y < 494; y++) begin
      drive(10, y, 1'b1, 1'b0, "vsync_x10");
      drive(700, y, 1'b1, 1'b0, "vsync_x700");
    end

    drive(5, 9, 1'b1, 1'b0, "addr321");
    drive(640, 9, 1'b1, 1'b0, "x640_blank");
    drive(639, 479, 1'b1, 1'b0, "last_pixel");
    drive(0, 480, 1'b1, 1'b0, "y480_blank");
    drain();

    drive(0, 0, 1'b1, 1'b0, "frame1");
    drive(1, 0, 1'b1, 1'b0, "after_frame1");
    drive(799, 524, 1'b1, 1'b0, "end_of_frame");
    drive(0, 0, 1'b1, 1'b0, "frame2");
    drive(2, 0, 1'b1, 1'b0, "after_frame2");
    drain();

    @(negedge clk_25MHz);
    force dut.r_frame_count = 16'hFFFF;
    #2;
    release dut.r_frame_count;
    m_fc = 16'hFFFF;
    drive(10, 10, 1'b1, 1'b0, "preload");
    drive(0, 0, 1'b1, 1'b0, "wrap");
    drive(4, 0, 1'b1, 1'b0, "after_wrap");

    drive(900, 600, 1'b1, 1'b0, "oor_900_600");
    drive(700, 600, 1'b1, 1'b0, "oor_700_600");
    drive(800, 490, 1'b1, 1'b0, "oor_800_490");
    drive(660, 520, 1'b1, 1'b0, "hs_y520");
    drain();

    for (int i = 0; i < 3; i++) drive(300 + i, 200, 1'b0, 1'b0, "pre_reset");
    do_reset(3);
    for (int i = 0; i < 6; i++) drive(303 + i, 200, 1'b1, 1'b0, "post_reset");
    drive(0, 0, 1'b1, 1'b0, "frame_after_reset");
    drain();

`ifdef VGA_TEST_PATTERN_EN
    drive(384, 0, 1'b1, 1'b1, "pat_x384");
    drive(130, 7, 1'b1, 1'b1, "pat_x130");
    drive(639, 479, 1'b1, 1'b1, "pat_x639");
    drive(700, 3, 1'b1, 1'b1, "pat_blank");
    drive(384, 0, 1'b1, 1'b0, "fb_after_pat");
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
